// File: rtl/muldiv_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer. It iterates shift-add or restoring-divide
// steps on an external 32-bit ALU and presents the 64-bit result on HI/LO.

`ifndef ALUCTRL_WIRENUM
`define ALUCTRL_WIRENUM 4
`endif
`ifndef OP_ADDU
`define OP_ADDU 4'b0001
`endif
`ifndef OP_SUBU
`define OP_SUBU 4'b0011
`endif

package muldiv_alu_pkg;
    typedef struct packed {
        logic CF;
        logic ZF;
        logic SF;
        logic OF;
    } FLAGS_t;
endpackage

module muldiv_seq
    import muldiv_alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [1:0]                    op,
    input  logic [XLEN-1:0]               src_a,
    input  logic [XLEN-1:0]               src_b,
    output logic                          busy,
    output logic                          done,
    output logic [XLEN-1:0]               hi,
    output logic [XLEN-1:0]               lo,
    output logic                          div_by_zero,
    output logic [XLEN-1:0]               alu_a,
    output logic [XLEN-1:0]               alu_b,
    output logic [`ALUCTRL_WIRENUM-1:0]   alu_mod,
    input  logic [XLEN-1:0]               alu_c,
    input  FLAGS_t                        alu_flags
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0]     CNT_LAST = CW'(XLEN - 1);
    localparam logic [CW-1:0]     CNT_ONE  = CW'(1);
    localparam logic [XLEN-1:0]   ONE      = XLEN'(1);
    localparam logic [2*XLEN-1:0] ONE2     = (2 * XLEN)'(1);

    typedef enum logic [1:0] {
        IDLE,
        PREP,
        ITER,
        FIX
    } state_t;

    state_t state, next_state;

    logic [1:0]      op_q;
    logic [XLEN-1:0] a_q, b_q;
    logic [XLEN-1:0] w_hi, w_lo;
    logic [XLEN-1:0] mcand, dvsr;
    logic            sign_a, sign_b;
    logic [CW-1:0]   cnt;

    logic            is_div, is_signed;
    logic [XLEN-1:0] mag_a, mag_b;
    logic [XLEN-1:0] div_shifted;
    logic            div_take;
    logic [2*XLEN-1:0] prod, neg_prod;
    logic [XLEN-1:0] neg_quo, neg_rem;
    logic            flags_unused;

    assign is_div    = op_q[1];
    assign is_signed = op_q[0];
    assign mag_a     = (is_signed && a_q[XLEN-1]) ? (~a_q + ONE) : a_q;
    assign mag_b     = (is_signed && b_q[XLEN-1]) ? (~b_q + ONE) : b_q;

    // A set top bit means the shifted remainder already exceeds any divisor.
    assign div_shifted = {w_hi[XLEN-2:0], w_lo[XLEN-1]};
    assign div_take    = w_hi[XLEN-1] || !alu_flags.CF;

    assign prod     = {w_hi, w_lo};
    assign neg_prod = ~prod + ONE2;
    assign neg_quo  = ~w_lo + ONE;
    assign neg_rem  = ~w_hi + ONE;

    assign busy         = (state != IDLE);
    assign flags_unused = ^{alu_flags.ZF, alu_flags.SF, alu_flags.OF};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        alu_a      = '0;
        alu_b      = '0;
        alu_mod    = `OP_ADDU;
        case (state)
            IDLE: begin
                if (start) next_state = PREP;
            end
            PREP: begin
                next_state = (is_div && mag_b == '0) ? FIX : ITER;
            end
            ITER: begin
                if (is_div) begin
                    alu_a   = div_shifted;
                    alu_b   = dvsr;
                    alu_mod = `OP_SUBU;
                end else begin
                    alu_a = w_hi;
                    alu_b = w_lo[0] ? mcand : '0;
                end
                if (cnt == '0) next_state = FIX;
            end
            FIX: begin
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Working registers and the architectural HI/LO, which only change in FIX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            w_hi        <= '0;
            w_lo        <= '0;
            mcand       <= '0;
            dvsr        <= '0;
            sign_a      <= 1'b0;
            sign_b      <= 1'b0;
            cnt         <= '0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= (state == FIX);
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q <= op;
                        a_q  <= src_a;
                        b_q  <= src_b;
                    end
                end
                PREP: begin
                    sign_a <= is_signed & a_q[XLEN-1];
                    sign_b <= is_signed & b_q[XLEN-1];
                    w_hi   <= '0;
                    cnt    <= CNT_LAST;
                    if (is_div) begin
                        w_lo <= mag_a;
                        dvsr <= mag_b;
                    end else begin
                        w_lo  <= mag_b;
                        mcand <= mag_a;
                    end
                end
                ITER: begin
                    cnt <= cnt - CNT_ONE;
                    if (is_div) begin
                        w_hi <= div_take ? alu_c : div_shifted;
                        w_lo <= {w_lo[XLEN-2:0], div_take};
                    end else begin
                        w_hi <= {alu_flags.CF, alu_c[XLEN-1:1]};
                        w_lo <= {alu_c[0], w_lo[XLEN-1:1]};
                    end
                end
                FIX: begin
                    if (!is_div) begin
                        {hi, lo}    <= (sign_a ^ sign_b) ? neg_prod : prod;
                        div_by_zero <= 1'b0;
                    end else if (dvsr == '0) begin
                        hi          <= a_q;
                        lo          <= '1;
                        div_by_zero <= 1'b1;
                    end else begin
                        lo          <= (sign_a ^ sign_b) ? neg_quo : w_lo;
                        hi          <= sign_a ? neg_rem : w_hi;
                        div_by_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: emulates the external ALU and compares results,
// timing and per-iteration ALU requests against arithmetic reference models.

`ifndef ALUCTRL_WIRENUM
`define ALUCTRL_WIRENUM 4
`endif
`ifndef OP_ADDU
`define OP_ADDU 4'b0001
`endif
`ifndef OP_SUBU
`define OP_SUBU 4'b0011
`endif

module tb_muldiv_seq;
    import muldiv_alu_pkg::*;

    localparam int MW = `ALUCTRL_WIRENUM;
    localparam logic [MW-1:0] MOD_ADD = `OP_ADDU;
    localparam logic [MW-1:0] MOD_SUB = `OP_SUBU;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [1:0]    op;
    logic [31:0]   src_a, src_b;
    logic          busy, done, div_by_zero;
    logic [31:0]   hi, lo;
    logic [31:0]   alu_a, alu_b, alu_c;
    logic [MW-1:0] alu_mod;
    FLAGS_t        alu_flags;
    logic [32:0]   alu_ext;

    int checks = 0;
    int errors = 0;

    muldiv_seq #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .src_a(src_a), .src_b(src_b), .busy(busy), .done(done),
        .hi(hi), .lo(lo), .div_by_zero(div_by_zero),
        .alu_a(alu_a), .alu_b(alu_b), .alu_mod(alu_mod),
        .alu_c(alu_c), .alu_flags(alu_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External ALU: ADDU carry-out or SUBU borrow on CF.
    always_comb begin
        alu_ext = '0;
        if (alu_mod == MOD_SUB) alu_ext = {1'b0, alu_a} - {1'b0, alu_b};
        else                    alu_ext = {1'b0, alu_a} + {1'b0, alu_b};
        alu_c        = alu_ext[31:0];
        alu_flags    = '0;
        alu_flags.CF = alu_ext[32];
        alu_flags.ZF = (alu_ext[31:0] == 32'd0);
        alu_flags.SF = alu_ext[31];
    end

    function automatic logic [31:0] mag(input logic [31:0] x, input logic sgn);
        return (sgn && x[31]) ? (32'd0 - x) : x;
    endfunction

    // Architectural result: {div_by_zero, hi, lo}
    function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        logic [31:0] q, r;
        case (o)
            2'd0: begin
                p = {32'd0, a} * {32'd0, b};
                return {1'b0, p};
            end
            2'd1: begin
                p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                return {1'b0, p};
            end
            2'd2: begin
                if (b == 32'd0) return {1'b1, a, 32'hFFFFFFFF};
                q = a / b;
                r = a % b;
                return {1'b0, r, q};
            end
            default: begin
                if (b == 32'd0) return {1'b1, a, 32'hFFFFFFFF};
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {1'b0, 32'd0, 32'h80000000};
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
                return {1'b0, r, q};
            end
        endcase
    endfunction

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'h80000000;
            2:       return 32'hFFFFFFFF;
            3:       return 32'($urandom_range(0, 20));
            4:       return 32'hFFFFFFFF - 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Issues one operation at cycle 0 and observes 40 cycles; performs no comparisons.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int done_cyc, output int n_done, output int busy_first,
                          output int busy_last, output logic [31:0] rhi, output logic [31:0] rlo,
                          output logic rdbz);
        done_cyc = -1; n_done = 0; busy_first = -1; busy_last = -1;
        rhi = 'x; rlo = 'x; rdbz = 1'bx;
        @(negedge clk);
        op = o; src_a = a; src_b = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (busy === 1'b1) begin
                if (busy_first < 0) busy_first = c;
                busy_last = c;
            end
            if (done === 1'b1) begin
                n_done++;
                if (done_cyc < 0) begin
                    done_cyc = c; rhi = hi; rlo = lo; rdbz = div_by_zero;
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; op = 2'd0; src_a = '0; src_b = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, div_by_zero} !== 3'b000) begin
            errors++; $display("[TB] FAIL reset_ctrl: got %b want 000", {busy, done, div_by_zero});
        end
        checks++;
        if ({hi, lo} !== 64'd0) begin
            errors++; $display("[TB] FAIL reset_hilo: got %h want 0", {hi, lo});
        end
        checks++;
        if ({alu_mod, alu_a, alu_b} !== {MOD_ADD, 64'd0}) begin
            errors++; $display("[TB] FAIL reset_alu: got %h want %h", {alu_mod, alu_a, alu_b}, {MOD_ADD, 64'd0});
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++; $display("[TB] FAIL reset_release: got %b want 00", {busy, done});
        end
    endtask

    task automatic test_directed();
        logic [1:0]  v_op [7] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        logic [31:0] v_a  [7] = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'h80000000, 32'd100, 32'hFFFFFFF9, 32'd7, 32'h80000000};
        logic [31:0] v_b  [7] = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd7, 32'd2, 32'hFFFFFFFE, 32'hFFFFFFFF};
        logic [31:0] v_hi [7] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h40000000, 32'd2, 32'hFFFFFFFF, 32'd1, 32'd0};
        logic [31:0] v_lo [7] = '{32'h00000001, 32'hFFFFFFF1, 32'd0, 32'h0000000E, 32'hFFFFFFFD, 32'hFFFFFFFD, 32'h80000000};
        int dc, nd, bf, bl;
        logic [31:0] rh, rl;
        logic rz;
        for (int k = 0; k < 7; k++) begin
            run_op(v_op[k], v_a[k], v_b[k], dc, nd, bf, bl, rh, rl, rz);
            checks++;
            if ({rz, rh, rl} !== {1'b0, v_hi[k], v_lo[k]}) begin
                errors++;
                $display("[TB] FAIL directed_%0d_result: got dbz=%b hi=%h lo=%h want dbz=0 hi=%h lo=%h",
                         k, rz, rh, rl, v_hi[k], v_lo[k]);
            end
            checks++;
            if (dc != 35 || nd != 1 || bf != 1 || bl != 34) begin
                errors++;
                $display("[TB] FAIL directed_%0d_timing: got done@%0d x%0d busy %0d..%0d want done@35 x1 busy 1..34",
                         k, dc, nd, bf, bl);
            end
        end
    endtask

    task automatic test_div_by_zero();
        int dc, nd, bf, bl;
        logic [31:0] rh, rl;
        logic rz;
        run_op(2'd2, 32'h00001234, 32'd0, dc, nd, bf, bl, rh, rl, rz);
        checks++;
        if ({rz, rh, rl} !== {1'b1, 32'h00001234, 32'hFFFFFFFF}) begin
            errors++; $display("[TB] FAIL dbz_result: got dbz=%b hi=%h lo=%h want dbz=1 hi=00001234 lo=ffffffff", rz, rh, rl);
        end
        checks++;
        if (dc != 3 || nd != 1 || bf != 1 || bl != 2) begin
            errors++; $display("[TB] FAIL dbz_timing: got done@%0d x%0d busy %0d..%0d want done@3 x1 busy 1..2", dc, nd, bf, bl);
        end
        run_op(2'd0, 32'd2, 32'd3, dc, nd, bf, bl, rh, rl, rz);
        checks++;
        if ({rz, rh, rl} !== {1'b0, 32'd0, 32'd6}) begin
            errors++; $display("[TB] FAIL dbz_clear: got dbz=%b hi=%h lo=%h want dbz=0 hi=0 lo=6", rz, rh, rl);
        end
    endtask

    task automatic test_start_ignored();
        int nd, first;
        logic [31:0] rh, rl;
        nd = 0; first = -1; rh = 'x; rl = 'x;
        @(negedge clk);
        op = 2'd0; src_a = 32'd1000; src_b = 32'd1000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 75; c++) begin
            if (done === 1'b1) begin
                nd++;
                if (first < 0) begin first = c; rh = hi; rl = lo; end
            end
            if (c == 10) begin
                start = 1'b1; op = 2'd2; src_a = 32'd9; src_b = 32'd4;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        checks++;
        if (nd != 1 || first != 35) begin
            errors++; $display("[TB] FAIL ignore_timing: got %0d done(s) first@%0d want 1 at 35", nd, first);
        end
        checks++;
        if ({rh, rl} !== {32'd0, 32'd1000000}) begin
            errors++; $display("[TB] FAIL ignore_result: got hi=%h lo=%h want hi=0 lo=000f4240", rh, rl);
        end
    endtask

    task automatic test_back_to_back();
        int nd, d1, d2;
        logic [31:0] rh, rl;
        nd = 0; d1 = -1; d2 = -1; rh = 'x; rl = 'x;
        @(negedge clk);
        op = 2'd0; src_a = 32'd7; src_b = 32'd6; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 80; c++) begin
            if (done === 1'b1) begin
                nd++;
                if (d1 < 0) d1 = c;
                else if (d2 < 0) begin d2 = c; rh = hi; rl = lo; end
            end
            if (c == 35) begin
                start = 1'b1; op = 2'd3; src_a = 32'hFFFFFF9C; src_b = 32'd7;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        checks++;
        if (nd != 2 || d1 != 35 || d2 != 70) begin
            errors++; $display("[TB] FAIL b2b_timing: got %0d dones at %0d,%0d want 2 at 35,70", nd, d1, d2);
        end
        checks++;
        if ({rh, rl} !== {32'hFFFFFFFE, 32'hFFFFFFF2}) begin
            errors++; $display("[TB] FAIL b2b_result: got hi=%h lo=%h want hi=fffffffe lo=fffffff2", rh, rl);
        end
    endtask

    task automatic test_reset_mid_op();
        int dc, nd, bf, bl;
        logic [31:0] rh, rl;
        logic rz;
        run_op(2'd2, 32'h00001234, 32'd0, dc, nd, bf, bl, rh, rl, rz);
        @(negedge clk);
        op = 2'd2; src_a = 32'd1000; src_b = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, div_by_zero, hi, lo} !== 67'd0) begin
            errors++; $display("[TB] FAIL midreset_state: got busy=%b done=%b dbz=%b hi=%h lo=%h want all 0",
                               busy, done, div_by_zero, hi, lo);
        end
        @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        for (int c = 0; c < 40; c++) begin
            if (done === 1'b1) nd++;
            @(negedge clk);
        end
        checks++;
        if (nd != 0) begin
            errors++; $display("[TB] FAIL midreset_nodone: got %0d done pulses want 0", nd);
        end
        run_op(2'd0, 32'd3, 32'd4, dc, nd, bf, bl, rh, rl, rz);
        checks++;
        if ({rz, rh, rl} !== {1'b0, 32'd0, 32'h0000000C} || dc != 35) begin
            errors++; $display("[TB] FAIL midreset_after: got hi=%h lo=%h done@%0d want hi=0 lo=0000000c done@35", rh, rl, dc);
        end
    endtask

    // Iteration i of shift-add presents partial product |a|*(|b| mod 2^i) >> i; restoring
    // divide presents twice the remainder of the top i dividend bits plus the next bit.
    task automatic test_alu_iter();
        logic [1:0]    o;
        logic [31:0]   a, b, exp_a, exp_b;
        logic [MW-1:0] exp_mod;
        logic [63:0]   ma, mb, tmp, rem;
        int it;
        for (int n = 0; n < 8; n++) begin
            o = 2'(n % 4);
            a = rand_operand();
            b = rand_operand();
            if (b == 32'd0) b = 32'd3;
            ma = {32'd0, mag(a, o[0])};
            mb = {32'd0, mag(b, o[0])};
            @(negedge clk);
            op = o; src_a = a; src_b = b; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            for (int c = 1; c <= 35; c++) begin
                exp_mod = MOD_ADD; exp_a = '0; exp_b = '0;
                if (c >= 2 && c <= 33) begin
                    it = c - 2;
                    if (o[1]) begin
                        rem     = (ma >> (32 - it)) % mb;
                        tmp     = (rem << 1) | ((ma >> (31 - it)) & 64'd1);
                        exp_a   = tmp[31:0];
                        exp_b   = mb[31:0];
                        exp_mod = MOD_SUB;
                    end else begin
                        tmp   = (ma * (mb & ((64'd1 << it) - 64'd1))) >> it;
                        exp_a = tmp[31:0];
                        exp_b = mb[it] ? ma[31:0] : 32'd0;
                    end
                end
                checks++;
                if ({alu_mod, alu_a, alu_b} !== {exp_mod, exp_a, exp_b}) begin
                    errors++;
                    $display("[TB] FAIL alu_iter op=%0d cyc=%0d: got mod=%h a=%h b=%h want mod=%h a=%h b=%h",
                             o, c, alu_mod, alu_a, alu_b, exp_mod, exp_a, exp_b);
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_random();
        logic [1:0]  o;
        logic [31:0] a, b, rh, rl;
        logic [64:0] exp;
        logic        rz;
        int dc, nd, bf, bl;
        for (int n = 0; n < 40; n++) begin
            o = 2'($urandom_range(0, 3));
            a = rand_operand();
            b = rand_operand();
            exp = model(o, a, b);
            run_op(o, a, b, dc, nd, bf, bl, rh, rl, rz);
            checks++;
            if ({rz, rh, rl} !== exp || nd != 1 || dc != (exp[64] ? 3 : 35)) begin
                errors++;
                $display("[TB] FAIL random op=%0d a=%h b=%h: got dbz=%b hi=%h lo=%h done@%0d x%0d want %h done@%0d",
                         o, a, b, rz, rh, rl, dc, nd, exp, exp[64] ? 3 : 35);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_directed();
        test_div_by_zero();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid_op();
        test_alu_iter();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
